// File: rtl/mips_pkg.sv
// Shared MIPS decode-stage definitions.
// Holds the default bubble instruction, register-file geometry, the bit
// positions of each instruction field and a 16->32 sign-extension helper.
// No ports.
package mips_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam int          REG_COUNT        = 32;
  localparam int          REG_ADDR_W       = 5;

  // Instruction field bit positions (inclusive MSB/LSB)
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/decode_if.sv
// Bus bundle between the fetch/write-back side and the decode stage.
// master : drives fetch (instruction, adderOutput, stall, flush) and
//          write-back (regWrite, writeReg, writeData); observes decoded outputs.
// slave  : the decode stage itself.
// There is no valid/ready handshake on this bus: the IF/ID latch loads every
// rising edge unless stall holds it or flush replaces it with a bubble;
// validD marks whether the latched word is a real instruction.
interface decode_if;
  import mips_pkg::*;

  logic [31:0]           instruction;
  logic [31:0]           adderOutput;
  logic                  stall;
  logic                  flush;
  logic                  regWrite;
  logic [REG_ADDR_W-1:0] writeReg;
  logic [31:0]           writeData;

  logic [31:0]           pcPlus4D;
  logic [31:0]           instrD;
  logic                  validD;
  logic [5:0]            opcode;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [4:0]            shamt;
  logic [5:0]            funct;
  logic [31:0]           readData1;
  logic [31:0]           readData2;
  logic [31:0]           signImm;

  modport master (
    output instruction, adderOutput, stall, flush, regWrite, writeReg, writeData,
    input  pcPlus4D, instrD, validD, opcode, rs, rt, rd, shamt, funct,
           readData1, readData2, signImm
  );

  modport slave (
    input  instruction, adderOutput, stall, flush, regWrite, writeReg, writeData,
    output pcPlus4D, instrD, validD, opcode, rs, rt, rd, shamt, funct,
           readData1, readData2, signImm
  );

endinterface

// File: rtl/decode_regfile.sv
// regfile: 32 x 32-bit register file, 2 asynchronous read ports, 1 write port.
// Register 0 always reads 0 and ignores writes. Synchronous active-high reset
// clears every register.
// Optional macro DECODE_WB_BYPASS_EN: a write in progress is forwarded to a
// read port addressing the same (non-zero) register in the same cycle.
// Ports:
//   clk, rst               clock, synchronous reset
//   raddr1_i/raddr2_i      read addresses
//   rdata1_o/rdata2_o      read data
//   we_i, waddr_i, wdata_i write enable, address, data
module regfile
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [31:0]           rdata1_o,
  output logic [31:0]           rdata2_o,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [31:0]           wdata_i
);

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [31:0] regs_q [REG_COUNT];
  logic        wr_live;

  assign wr_live = we_i && (waddr_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (wr_live) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
    // wr_live already excludes r0, so forwarding never breaks the zero register
    if (BYPASS && wr_live && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (BYPASS && wr_live && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
  end

endmodule

// File: rtl/decode.sv
// decode: MIPS instruction-decode stage. Holds the IF/ID pipeline latch,
// splits the latched instruction into fields, sign-extends the immediate and
// reads the register file at rs/rt.
// Optional macro DECODE_WB_BYPASS_EN (passed through to regfile): same-cycle
// write-back forwarding onto readData1/readData2.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (priority over stall/flush/regWrite)
//   bus  decode_if.slave: fetch inputs, write-back inputs, decoded outputs
module decode
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);

  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;

  // flush wins over stall; the PC+4 still follows the fetch stage on flush
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_WORD;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (bus.flush) begin
      instr_q    <= NOP_WORD;
      pc_plus4_q <= bus.adderOutput;
      valid_q    <= 1'b0;
    end else if (!bus.stall) begin
      instr_q    <= bus.instruction;
      pc_plus4_q <= bus.adderOutput;
      valid_q    <= 1'b1;
    end
  end

  assign bus.instrD   = instr_q;
  assign bus.pcPlus4D = pc_plus4_q;
  assign bus.validD   = valid_q;
  assign bus.opcode   = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign bus.rs       = instr_q[RS_MSB:RS_LSB];
  assign bus.rt       = instr_q[RT_MSB:RT_LSB];
  assign bus.rd       = instr_q[RD_MSB:RD_LSB];
  assign bus.shamt    = instr_q[SHAMT_MSB:SHAMT_LSB];
  assign bus.funct    = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign bus.signImm  = sign_ext16(instr_q[IMM_MSB:IMM_LSB]);

  regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (instr_q[RS_MSB:RS_LSB]),
    .raddr2_i (instr_q[RT_MSB:RT_LSB]),
    .rdata1_o (bus.readData1),
    .rdata2_o (bus.readData2),
    .we_i     (bus.regWrite),
    .waddr_i  (bus.writeReg),
    .wdata_i  (bus.writeData)
  );

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter NOP_WORD, default 32'h0000_0000; instruction word loaded into the IF/ID latch on reset or flush.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 instruction  input  32  instruction word from the fetch stage.
REQ-005 adderOutput  input  32  PC+4 from the fetch stage.
REQ-006 stall  input  1  hold the IF/ID latch.
REQ-007 flush  input  1  replace the latched instruction with NOP_WORD (taken branch, pcsrc=1).
REQ-008 regWrite  input  1  write-back enable.
REQ-009 writeReg  input  5  write-back destination register.
REQ-010 writeData  input  32  write-back data.
REQ-011 pcPlus4D  output  32  latched PC+4.
REQ-012 instrD  output  32  latched instruction.
REQ-013 validD  output  1  latched instruction is real (not a bubble).
REQ-014 opcode  output  6  instrD[31:26].
REQ-015 rs, rt, rd  output  5 each  instrD[25:21], [20:16], [15:11].
REQ-016 shamt  output  5  instrD[10:6].
REQ-017 funct  output  6  instrD[5:0].
REQ-018 readData1, readData2  output  32 each  register-file contents at rs and rt.
REQ-019 signImm  output  32  instrD[15:0] sign-extended to 32 bits.

Function
REQ-020 IF/ID latch loads instruction and adderOutput every rising edge, sets validD=1, when stall=0 and flush=0.
REQ-021 stall=1 and flush=0: instrD, pcPlus4D and validD hold their values.
REQ-022 flush=1: instrD=NOP_WORD and validD=0; pcPlus4D loads adderOutput; flush overrides stall.
REQ-023 Field outputs (REQ-014..017) and signImm are combinational from instrD; zero added latency.
REQ-024 signImm = {16{instrD[15]}, instrD[15:0]}.
REQ-025 Register file: 32 x 32-bit; register 0 reads 0 always, and writes to it are ignored.
REQ-026 Write occurs on rising edge when regWrite=1 and writeReg!=0; the write is not blocked by stall or flush.
REQ-027 Reads are combinational and asynchronous on rs/rt; without bypass, a value written at edge N is visible after edge N.
REQ-028 Simultaneous read and write of the same register: result is per REQ-033/034.
REQ-029 Latch updates and register-file writes are independent; both occur in the same cycle when both are enabled.

Reset
REQ-030 rst=1 at a rising edge: instrD=NOP_WORD, pcPlus4D=0, validD=0, all 32 registers cleared to 0.
REQ-031 rst has priority over stall, flush and regWrite; a write in the reset cycle is discarded.
REQ-032 Reset asserted mid-operation discards the in-flight instruction; outputs read 0 (fields of NOP_WORD) from the following cycle.

Configuration
REQ-033 With DECODE_WB_BYPASS_EN defined: when regWrite=1, writeReg!=0 and writeReg equals rs (or rt), readData1 (readData2) returns writeData in the same cycle.
REQ-034 Without DECODE_WB_BYPASS_EN: readData returns the stored (old) value until the edge completes the write.

Structure
REQ-035 Shared package mips_pkg holds NOP_WORD default, REG_COUNT=32, REG_ADDR_W=5, and field bit-position constants.
REQ-036 Register file is a sub-module named regfile (2 read ports, 1 write port, sync reset, bypass option); decode instantiates it alongside the IF/ID latch.

Verification
REQ-037 rst=1 for one edge, then instruction=32'h2008_0005, adderOutput=4 -> after the next edge: validD=1, opcode=6'h08, rt=8, signImm=5, pcPlus4D=4.
REQ-038 instruction=32'h2009_FFFF -> signImm=32'hFFFF_FFFF.
REQ-039 stall=1 for 2 cycles while instruction changes -> instrD and pcPlus4D unchanged; stall and flush both asserted -> instrD=0, validD=0.
REQ-040 regWrite=1, writeReg=0, writeData=32'hDEAD_BEEF, then read rs=0 -> readData1=0.
REQ-041 regWrite=1, writeReg=9, writeData=32'h1234_5678, instrD rs=9 in the same cycle -> readData1=32'h1234_5678 with bypass, old value without; 32'h1234_5678 after the edge in both builds.
REQ-042 Write r5=7, assert rst, then read r5 -> readData=0 and validD=0.
